// File: rtl/spi_txn_controller_if.sv
// Bus bundle between the SPI transaction controller and its surroundings.
// The slave view belongs to the controller. The master view belongs to
// whatever drives chip select and edge pulses and reads back the strobes.
interface spi_txn_controller_if;
  // Conditioned SPI inputs and the shift register's parallel output
  logic       cs_n;
  logic       sclk_posedge;
  logic       fault_hold;
  logic [7:0] sr_data;

  // Datapath strobes
  logic       addr_we;
  logic       sr_load;
  logic       dm_we;
  logic       miso_en;

  // Status and debug
  logic       busy;
  logic       txn_is_read;
  logic       txn_done;
  logic       txn_abort;
  logic [3:0] state_out;

  modport slave (
    input  cs_n,
    input  sclk_posedge,
    input  fault_hold,
    input  sr_data,
    output addr_we,
    output sr_load,
    output dm_we,
    output miso_en,
    output busy,
    output txn_is_read,
    output txn_done,
    output txn_abort,
    output state_out
  );

  modport master (
    output cs_n,
    output sclk_posedge,
    output fault_hold,
    output sr_data,
    input  addr_we,
    input  sr_load,
    input  dm_we,
    input  miso_en,
    input  busy,
    input  txn_is_read,
    input  txn_done,
    input  txn_abort,
    input  state_out
  );
endinterface

// File: rtl/spi_txn_controller.sv
// SPI memory transaction sequencer.
// It counts qualified SCLK rising-edge pulses while chip select is low.
// After 8 edges it decodes the command byte: bit 0 is R/W and bits 7:1 are
// the address. It then runs either a read flow (address latch, wait for
// memory, parallel load, shift out) or a write flow (address latch, shift
// in, commit). Chip select going high mid-frame aborts the transaction
// cleanly. Once a write commit has started, it always completes.
module spi_txn_controller #(
  parameter int CNT_BITS       = 4,
  parameter int RD_WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spi_txn_controller_if.slave  bus
);

  // State encodings are fixed because state_out drives LEDs and debug tools
  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_CMD       = 4'd1;
  localparam logic [3:0] S_LATCH     = 4'd2;
  localparam logic [3:0] S_RD_WAIT   = 4'd3;
  localparam logic [3:0] S_RD_LOAD   = 4'd4;
  localparam logic [3:0] S_RD_SHIFT  = 4'd5;
  localparam logic [3:0] S_WR_SHIFT  = 4'd6;
  localparam logic [3:0] S_WR_COMMIT = 4'd7;
  localparam logic [3:0] S_DONE      = 4'd8;

  // The wait counter only has to reach RD_WAIT_CYCLES-1
  localparam int WAIT_BITS = (RD_WAIT_CYCLES > 1) ? $clog2(RD_WAIT_CYCLES) : 1;
  localparam logic [WAIT_BITS-1:0] WAIT_LAST = WAIT_BITS'(RD_WAIT_CYCLES - 1);

  // The bit counter idles at 0 and saturates at 8 at the end of a data byte
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(7);
  localparam logic [CNT_BITS-1:0] CNT_FULL = CNT_BITS'(8);
  localparam logic [CNT_BITS-1:0] CNT_ZERO = '0;

  logic [3:0]           state_reg;
  logic [3:0]           state_next;
  logic [CNT_BITS-1:0]  bit_cnt_reg;
  logic [CNT_BITS-1:0]  bit_cnt_next;
  logic [WAIT_BITS-1:0] wait_cnt_reg;
  logic [WAIT_BITS-1:0] wait_cnt_next;
  logic                 is_read_reg;
  logic                 is_read_next;
  logic                 done_reg;
  logic                 done_next;
  logic                 abort_reg;
  logic                 abort_next;

  // Only the R/W flag matters here; the address bits go straight to the latch
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.sr_data[7:1];

  // An SCLK edge counts only while selected and not frozen by fault injection.
  // Because of this, a coincident chip-select release always beats the edge.
  logic edge_ok;
  assign edge_ok = bus.sclk_posedge & ~bus.fault_hold & ~bus.cs_n;

  // Next-state, counter, capture and pulse logic
  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    wait_cnt_next = wait_cnt_reg;
    is_read_next  = is_read_reg;
    abort_next    = 1'b0;

    case (state_reg)
      S_IDLE: begin
        bit_cnt_next  = CNT_ZERO;
        wait_cnt_next = '0;
        if (!bus.cs_n) begin
          state_next = S_CMD;
        end
      end

      S_CMD: begin
        if (bus.cs_n) begin
          state_next   = S_IDLE;
          abort_next   = 1'b1;
          bit_cnt_next = CNT_ZERO;
        end else if (edge_ok) begin
          if (bit_cnt_reg == CNT_LAST) begin
            // The command byte is complete. Restart the count for the data byte.
            state_next   = S_LATCH;
            bit_cnt_next = CNT_ZERO;
          end else begin
            bit_cnt_next = bit_cnt_reg + CNT_BITS'(1);
          end
        end
      end

      S_LATCH: begin
        if (bus.cs_n) begin
          state_next   = S_IDLE;
          abort_next   = 1'b1;
          bit_cnt_next = CNT_ZERO;
        end else begin
          is_read_next = bus.sr_data[0];
          if (bus.sr_data[0]) begin
            state_next    = S_RD_WAIT;
            wait_cnt_next = '0;
          end else begin
            state_next = S_WR_SHIFT;
          end
        end
      end

      S_RD_WAIT: begin
        // Give the address latch and the memory read register time to settle
        if (bus.cs_n) begin
          state_next    = S_IDLE;
          abort_next    = 1'b1;
          bit_cnt_next  = CNT_ZERO;
          wait_cnt_next = '0;
        end else if (wait_cnt_reg == WAIT_LAST) begin
          state_next    = S_RD_LOAD;
          wait_cnt_next = '0;
        end else begin
          wait_cnt_next = wait_cnt_reg + WAIT_BITS'(1);
        end
      end

      S_RD_LOAD: begin
        if (bus.cs_n) begin
          state_next   = S_IDLE;
          abort_next   = 1'b1;
          bit_cnt_next = CNT_ZERO;
        end else begin
          state_next = S_RD_SHIFT;
        end
      end

      S_RD_SHIFT, S_WR_SHIFT: begin
        if (bus.cs_n) begin
          state_next   = S_IDLE;
          abort_next   = 1'b1;
          bit_cnt_next = CNT_ZERO;
        end else if (edge_ok) begin
          if (bit_cnt_reg == CNT_LAST) begin
            // The data byte is complete. The count stays at 8 until IDLE.
            bit_cnt_next = CNT_FULL;
            state_next   = (state_reg == S_RD_SHIFT) ? S_DONE : S_WR_COMMIT;
          end else begin
            bit_cnt_next = bit_cnt_reg + CNT_BITS'(1);
          end
        end
      end

      S_WR_COMMIT: begin
        // A commit in progress finishes even if chip select has just gone high
        state_next = S_DONE;
      end

      S_DONE: begin
        // Ignore further edges and wait for the host to release chip select
        if (bus.cs_n) begin
          state_next = S_IDLE;
        end
      end

      default: begin
        state_next   = S_IDLE;
        bit_cnt_next = CNT_ZERO;
      end
    endcase

    done_next = (state_next == S_DONE) && (state_reg != S_DONE);
  end

  // State and counter registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      bit_cnt_reg  <= CNT_ZERO;
      wait_cnt_reg <= '0;
      is_read_reg  <= 1'b0;
      done_reg     <= 1'b0;
      abort_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      wait_cnt_reg <= wait_cnt_next;
      is_read_reg  <= is_read_next;
      done_reg     <= done_next;
      abort_reg    <= abort_next;
    end
  end

  // Moore decodes of the registered state, so strobes are glitch-free
  assign bus.addr_we     = (state_reg == S_LATCH);
  assign bus.sr_load     = (state_reg == S_RD_LOAD);
  assign bus.dm_we       = (state_reg == S_WR_COMMIT);
  assign bus.miso_en     = (state_reg == S_RD_LOAD) || (state_reg == S_RD_SHIFT);
  assign bus.busy        = (state_reg != S_IDLE);
  assign bus.txn_is_read = is_read_reg;
  assign bus.txn_done    = done_reg;
  assign bus.txn_abort   = abort_reg;
  assign bus.state_out   = state_reg;

endmodule

// File: tb/tb_spi_txn_controller.sv
// Scenario bench for spi_txn_controller. Each scenario pushes its expected
// strobe totals onto a scoreboard queue before it drives the frame. It pops
// that entry after the frame ends and compares it with the pulses counted by
// a monitor. Each scenario also checks cycle-exact state and strobe timing.
module tb_spi_txn_controller;
  localparam int GAP = 10;  // clk cycles between SCLK edges (>= 2*(RD_WAIT+3))

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  spi_txn_controller_if ifc();

  spi_txn_controller #(.CNT_BITS(4), .RD_WAIT_CYCLES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Strobe activity, counted in clk cycles
  int cnt_aw = 0, cnt_ld = 0, cnt_we = 0, cnt_dn = 0, cnt_ab = 0;
  always @(negedge clk) begin
    cnt_aw <= cnt_aw + (ifc.addr_we   ? 1 : 0);
    cnt_ld <= cnt_ld + (ifc.sr_load   ? 1 : 0);
    cnt_we <= cnt_we + (ifc.dm_we     ? 1 : 0);
    cnt_dn <= cnt_dn + (ifc.txn_done  ? 1 : 0);
    cnt_ab <= cnt_ab + (ifc.txn_abort ? 1 : 0);
  end

  typedef struct {
    string      name;
    logic [39:0] counts;  // {addr_we, sr_load, dm_we, txn_done, txn_abort}
    logic        is_read;
  } exp_t;
  exp_t exp_q[$];

  int s_aw, s_ld, s_we, s_dn, s_ab;
  logic [7:0] sr_model = 8'h00;

  task automatic open_txn(input string name, input bit [7:0] aw, input bit [7:0] ld,
                          input bit [7:0] we, input bit [7:0] dn, input bit [7:0] ab,
                          input bit rd);
    exp_t e;
    e.name    = name;
    e.counts  = {aw, ld, we, dn, ab};
    e.is_read = rd;
    exp_q.push_back(e);
    s_aw = cnt_aw; s_ld = cnt_ld; s_we = cnt_we; s_dn = cnt_dn; s_ab = cnt_ab;
  endtask

  function automatic logic [39:0] obs_counts();
    return {8'(cnt_aw - s_aw), 8'(cnt_ld - s_ld), 8'(cnt_we - s_we),
            8'(cnt_dn - s_dn), 8'(cnt_ab - s_ab)};
  endfunction

  task automatic realign();
    @(posedge clk); #1;
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One qualified-or-held SCLK pulse. The shift register model moves on unheld edges.
  task automatic send_edge(input bit b, input bit hold);
    ifc.sclk_posedge = 1'b1;
    ifc.fault_hold   = hold;
    @(posedge clk); #1;
    ifc.sclk_posedge = 1'b0;
    ifc.fault_hold   = 1'b0;
    if (!hold) sr_model = {sr_model[6:0], b};
    ifc.sr_data = sr_model;
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      if (i > 0) gap(GAP);
      send_edge(v[7-i], 1'b0);
    end
  endtask

  task automatic select();
    ifc.cs_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic close_txn();
    exp_t e;
    logic [39:0] obs;
    realign();
    obs = obs_counts();
    if (exp_q.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL scoreboard_empty got 0 entries want 1");
    end else begin
      e = exp_q.pop_front();
      n_tests++;
      if (obs !== e.counts) begin
        n_fail++;
        $display("FAIL %s strobe_counts got %h want %h", e.name, obs, e.counts);
      end
      n_tests++;
      if (ifc.txn_is_read !== e.is_read) begin
        n_fail++;
        $display("FAIL %s txn_is_read got %b want %b", e.name, ifc.txn_is_read, e.is_read);
      end
      $display("[TB] txn %-12s counts aw/ld/we/dn/ab=%h is_read=%b", e.name, obs, ifc.txn_is_read);
    end
  endtask

  task automatic test_reset();
    #23;
    n_tests++;
    if ({ifc.state_out, ifc.addr_we, ifc.sr_load, ifc.dm_we, ifc.miso_en, ifc.busy,
         ifc.txn_is_read, ifc.txn_done, ifc.txn_abort} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs got state=%0d aw=%b ld=%b we=%b me=%b busy=%b rd=%b dn=%b ab=%b want all 0",
               ifc.state_out, ifc.addr_we, ifc.sr_load, ifc.dm_we, ifc.miso_en, ifc.busy,
               ifc.txn_is_read, ifc.txn_done, ifc.txn_abort);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    gap(3);
    @(negedge clk);
    n_tests++;
    if (ifc.state_out !== 4'd0 || ifc.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset got state=%0d busy=%b want 0/0", ifc.state_out, ifc.busy);
    end
    realign();
  endtask

  task automatic test_write(input string name, input logic [6:0] addr, input logic [7:0] data);
    open_txn(name, 1, 0, 1, 1, 0, 1'b0);
    select();
    @(negedge clk);
    n_tests++;
    if (ifc.state_out !== 4'd1 || ifc.busy !== 1'b1) begin
      n_fail++; $display("FAIL %s cmd_state got %0d busy=%b want 1/1", name, ifc.state_out, ifc.busy);
    end
    realign();
    send_bits({addr, 1'b0}, 8);
    @(negedge clk);
    n_tests++;
    if (ifc.addr_we !== 1'b1 || ifc.state_out !== 4'd2) begin
      n_fail++; $display("FAIL %s latch got aw=%b state=%0d want 1/2", name, ifc.addr_we, ifc.state_out);
    end
    @(negedge clk);
    n_tests++;
    if (ifc.addr_we !== 1'b0 || ifc.state_out !== 4'd6 || ifc.txn_is_read !== 1'b0) begin
      n_fail++; $display("FAIL %s wr_shift got aw=%b state=%0d rd=%b want 0/6/0", name, ifc.addr_we, ifc.state_out, ifc.txn_is_read);
    end
    realign(); gap(GAP);
    send_bits(data, 8);
    @(negedge clk);
    n_tests++;
    if (ifc.dm_we !== 1'b1 || ifc.state_out !== 4'd7) begin
      n_fail++; $display("FAIL %s commit got we=%b state=%0d want 1/7", name, ifc.dm_we, ifc.state_out);
    end
    @(negedge clk);
    n_tests++;
    if (ifc.dm_we !== 1'b0 || ifc.state_out !== 4'd8 || ifc.txn_done !== 1'b1) begin
      n_fail++; $display("FAIL %s done_entry got we=%b state=%0d dn=%b want 0/8/1", name, ifc.dm_we, ifc.state_out, ifc.txn_done);
    end
    @(negedge clk);
    n_tests++;
    if (ifc.txn_done !== 1'b0 || ifc.state_out !== 4'd8) begin
      n_fail++; $display("FAIL %s done_hold got dn=%b state=%0d want 0/8", name, ifc.txn_done, ifc.state_out);
    end
    realign(); gap(GAP);
    send_edge(1'b1, 1'b0);
    @(negedge clk);
    n_tests++;
    if (ifc.state_out !== 4'd8) begin
      n_fail++; $display("FAIL %s done_ignores_edge got state=%0d want 8", name, ifc.state_out);
    end
    realign();
    ifc.cs_n = 1'b1;
    @(negedge clk); @(negedge clk);
    n_tests++;
    if (ifc.state_out !== 4'd0 || ifc.busy !== 1'b0) begin
      n_fail++; $display("FAIL %s back_to_idle got state=%0d busy=%b want 0/0", name, ifc.state_out, ifc.busy);
    end
    close_txn();
    gap(GAP);
  endtask

  task automatic test_read();
    open_txn("read_a1", 1, 1, 0, 1, 0, 1'b1);
    select();
    send_bits(8'h03, 8);
    @(negedge clk);
    n_tests++;
    if (ifc.addr_we !== 1'b1 || ifc.state_out !== 4'd2) begin
      n_fail++; $display("FAIL rd_latch got aw=%b state=%0d want 1/2", ifc.addr_we, ifc.state_out);
    end
    @(negedge clk);
    n_tests++;
    if (ifc.state_out !== 4'd3 || ifc.txn_is_read !== 1'b1) begin
      n_fail++; $display("FAIL rd_wait0 got state=%0d rd=%b want 3/1", ifc.state_out, ifc.txn_is_read);
    end
    @(negedge clk);
    n_tests++;
    if (ifc.state_out !== 4'd3 || ifc.sr_load !== 1'b0) begin
      n_fail++; $display("FAIL rd_wait1 got state=%0d ld=%b want 3/0", ifc.state_out, ifc.sr_load);
    end
    @(negedge clk);
    n_tests++;
    if (ifc.state_out !== 4'd4 || ifc.sr_load !== 1'b1 || ifc.miso_en !== 1'b1) begin
      n_fail++; $display("FAIL rd_load got state=%0d ld=%b me=%b want 4/1/1", ifc.state_out, ifc.sr_load, ifc.miso_en);
    end
    @(negedge clk);
    n_tests++;
    if (ifc.state_out !== 4'd5 || ifc.sr_load !== 1'b0 || ifc.miso_en !== 1'b1) begin
      n_fail++; $display("FAIL rd_shift_entry got state=%0d ld=%b me=%b want 5/0/1", ifc.state_out, ifc.sr_load, ifc.miso_en);
    end
    realign(); gap(GAP);
    send_bits(8'hA5, 7);
    @(negedge clk);
    n_tests++;
    if (ifc.state_out !== 4'd5 || ifc.miso_en !== 1'b1) begin
      n_fail++; $display("FAIL rd_shift_7 got state=%0d me=%b want 5/1", ifc.state_out, ifc.miso_en);
    end
    realign(); gap(GAP);
    send_edge(1'b1, 1'b0);
    @(negedge clk);
    n_tests++;
    if (ifc.state_out !== 4'd8 || ifc.miso_en !== 1'b0 || ifc.txn_done !== 1'b1 || ifc.dm_we !== 1'b0) begin
      n_fail++; $display("FAIL rd_done got state=%0d me=%b dn=%b we=%b want 8/0/1/0", ifc.state_out, ifc.miso_en, ifc.txn_done, ifc.dm_we);
    end
    realign();
    ifc.cs_n = 1'b1;
    @(negedge clk); @(negedge clk);
    n_tests++;
    if (ifc.state_out !== 4'd0) begin
      n_fail++; $display("FAIL rd_idle got state=%0d want 0", ifc.state_out);
    end
    close_txn();
    gap(GAP);
  endtask

  task automatic test_abort_write();
    open_txn("abort_wr", 1, 0, 0, 0, 1, 1'b0);
    select();
    send_bits(8'h02, 8);
    gap(GAP);
    send_bits(8'h55, 4);
    gap(3);
    ifc.cs_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (ifc.state_out !== 4'd0 || ifc.txn_abort !== 1'b1 || ifc.dm_we !== 1'b0) begin
      n_fail++; $display("FAIL abort_pulse got state=%0d ab=%b we=%b want 0/1/0", ifc.state_out, ifc.txn_abort, ifc.dm_we);
    end
    @(negedge clk);
    n_tests++;
    if (ifc.txn_abort !== 1'b0) begin
      n_fail++; $display("FAIL abort_one_clk got ab=%b want 0", ifc.txn_abort);
    end
    close_txn();
    gap(GAP);
    test_write("write_a5", 7'h05, 8'hA3);
  endtask

  task automatic test_fault_hold();
    logic [7:0] cmd;
    int k;
    bit hold;
    cmd = 8'h02;
    k = 0;
    open_txn("fault_hold", 1, 0, 0, 0, 1, 1'b0);
    select();
    for (int i = 0; i < 11; i++) begin
      if (i > 0) gap(GAP);
      if (i == 10) begin
        @(negedge clk);
        n_tests++;
        if (ifc.state_out !== 4'd1) begin
          n_fail++; $display("FAIL held_edges_uncounted got state=%0d want 1", ifc.state_out);
        end
        realign();
      end
      hold = (i == 2 || i == 5 || i == 8);
      send_edge(hold ? 1'b1 : cmd[7-k], hold);
      if (!hold) k++;
    end
    @(negedge clk);
    n_tests++;
    if (ifc.addr_we !== 1'b1 || ifc.state_out !== 4'd2) begin
      n_fail++; $display("FAIL held_latch got aw=%b state=%0d want 1/2", ifc.addr_we, ifc.state_out);
    end
    @(negedge clk);
    n_tests++;
    if (ifc.state_out !== 4'd6) begin
      n_fail++; $display("FAIL held_wr_shift got state=%0d want 6", ifc.state_out);
    end
    realign();
    ifc.cs_n = 1'b1;
    @(negedge clk); @(negedge clk);
    n_tests++;
    if (ifc.state_out !== 4'd0 || ifc.txn_abort !== 1'b1) begin
      n_fail++; $display("FAIL held_abort got state=%0d ab=%b want 0/1", ifc.state_out, ifc.txn_abort);
    end
    close_txn();
    gap(GAP);
  endtask

  task automatic test_cs_edge_race();
    open_txn("cs_on_8th", 1, 0, 0, 0, 1, 1'b0);
    select();
    send_bits(8'h02, 8);
    gap(GAP);
    send_bits(8'hFF, 7);
    gap(GAP);
    ifc.sclk_posedge = 1'b1;
    ifc.cs_n = 1'b1;
    @(posedge clk); #1;
    ifc.sclk_posedge = 1'b0;
    @(negedge clk);
    n_tests++;
    if (ifc.state_out !== 4'd0 || ifc.txn_abort !== 1'b1 || ifc.dm_we !== 1'b0) begin
      n_fail++; $display("FAIL cs_wins got state=%0d ab=%b we=%b want 0/1/0", ifc.state_out, ifc.txn_abort, ifc.dm_we);
    end
    close_txn();
    gap(GAP);

    open_txn("cs_in_commit", 1, 0, 1, 1, 0, 1'b0);
    select();
    send_bits(8'h02, 8);
    gap(GAP);
    send_bits(8'h3C, 8);
    ifc.cs_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (ifc.dm_we !== 1'b1 || ifc.state_out !== 4'd7) begin
      n_fail++; $display("FAIL commit_survives got we=%b state=%0d want 1/7", ifc.dm_we, ifc.state_out);
    end
    @(negedge clk);
    n_tests++;
    if (ifc.state_out !== 4'd8 || ifc.txn_done !== 1'b1 || ifc.txn_abort !== 1'b0) begin
      n_fail++; $display("FAIL commit_done got state=%0d dn=%b ab=%b want 8/1/0", ifc.state_out, ifc.txn_done, ifc.txn_abort);
    end
    @(negedge clk);
    n_tests++;
    if (ifc.state_out !== 4'd0) begin
      n_fail++; $display("FAIL commit_idle got state=%0d want 0", ifc.state_out);
    end
    close_txn();
    gap(GAP);
  endtask

  task automatic test_reset_mid_read();
    open_txn("reset_rd", 2, 1, 0, 0, 1, 1'b0);
    select();
    send_bits(8'h03, 8);
    gap(GAP);
    send_bits(8'hF0, 3);
    gap(3);
    @(negedge clk);
    n_tests++;
    if (ifc.state_out !== 4'd5 || ifc.miso_en !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset got state=%0d me=%b want 5/1", ifc.state_out, ifc.miso_en);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (ifc.state_out !== 4'd0 || ifc.miso_en !== 1'b0 || ifc.busy !== 1'b0 ||
        ifc.txn_is_read !== 1'b0 || ifc.txn_done !== 1'b0 || ifc.txn_abort !== 1'b0) begin
      n_fail++; $display("FAIL async_reset got state=%0d me=%b busy=%b rd=%b dn=%b ab=%b want all 0",
                         ifc.state_out, ifc.miso_en, ifc.busy, ifc.txn_is_read, ifc.txn_done, ifc.txn_abort);
    end
    @(posedge clk); #3;
    rst_n = 1'b1;
    sr_model = 8'h00;
    ifc.sr_data = sr_model;
    realign();
    @(negedge clk);
    n_tests++;
    if (ifc.state_out !== 4'd1) begin
      n_fail++; $display("FAIL resume_cmd got state=%0d want 1", ifc.state_out);
    end
    realign();
    send_bits(8'h02, 7);
    @(negedge clk);
    n_tests++;
    if (ifc.state_out !== 4'd1) begin
      n_fail++; $display("FAIL count_from_zero got state=%0d want 1", ifc.state_out);
    end
    realign(); gap(GAP);
    send_edge(1'b0, 1'b0);
    @(negedge clk);
    n_tests++;
    if (ifc.state_out !== 4'd2 || ifc.addr_we !== 1'b1) begin
      n_fail++; $display("FAIL resume_latch got state=%0d aw=%b want 2/1", ifc.state_out, ifc.addr_we);
    end
    realign();
    ifc.cs_n = 1'b1;
    @(negedge clk); @(negedge clk);
    n_tests++;
    if (ifc.state_out !== 4'd0) begin
      n_fail++; $display("FAIL reset_rd_idle got state=%0d want 0", ifc.state_out);
    end
    close_txn();
  endtask

  initial begin
    ifc.cs_n         = 1'b1;
    ifc.sclk_posedge = 1'b0;
    ifc.fault_hold   = 1'b0;
    ifc.sr_data      = 8'h00;
    test_reset();
    test_write("write_a1", 7'h01, 8'h55);
    test_read();
    test_abort_write();
    test_fault_hold();
    test_cs_edge_race();
    test_reset_mid_read();
    n_tests++;
    if (exp_q.size() !== 0) begin
      n_fail++; $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_txn_controller.md
Name: spi_txn_controller

Overview:
- Transaction sequencer for the SPI memory datapath. Drives the shift register parallel load, the address latch write enable, the data memory write enable and the MISO tristate enable.
- Consumes conditioned chip select plus one-clk SCLK edge pulses from the input conditioners. Decodes the command byte from the shift register's parallel output.
- Replaces the free-running edge-triggered FSM with a fully synchronous, resettable, abortable controller.

Parameters:
- CNT_BITS, 4, width of the SCLK bit counter; counts 0..8.
- RD_WAIT_CYCLES, 2, clk cycles between address latch and shift-register load. Covers the latch-register plus memory-read-register latency.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- cs_n  input  1  conditioned chip select, active low.
- sclk_posedge  input  1  one-clk pulse per SCLK rising edge.
- fault_hold  input  1  level; when 1, sclk_posedge is not counted. Same gating as the shift register's fault injector.
- sr_data  input  8  shift register parallel output; bit 0 is the R/W flag (1 = read), bits 7:1 are the address.
- addr_we  output  1  address latch write enable.
- sr_load  output  1  shift register parallel load from data memory.
- dm_we  output  1  data memory write enable.
- miso_en  output  1  MISO tristate enable.
- busy  output  1  1 in any state except IDLE.
- txn_is_read  output  1  R/W flag captured during LATCH.
- txn_done  output  1  one-clk pulse on entry to DONE.
- txn_abort  output  1  one-clk pulse when cs_n deasserts mid-frame.
- state_out  output  4  current state encoding, for leds/debug.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, bit_cnt=0, wait_cnt=0, txn_is_read=0. All strobes, txn_done and txn_abort are 0.
- Reset asserted mid-transaction returns to IDLE immediately with no memory write.
- Counted edge = sclk_posedge & ~fault_hold & ~cs_n.
- addr_we, sr_load, dm_we, miso_en and busy are Moore decodes of the registered state. txn_done and txn_abort are registered pulses.
- State encodings: IDLE=0, CMD=1, LATCH=2, RD_WAIT=3, RD_LOAD=4, RD_SHIFT=5, WR_SHIFT=6, WR_COMMIT=7, DONE=8.
- IDLE: bit_cnt=0. If cs_n=0, go to CMD.
- CMD: bit_cnt increments on each counted edge. On the edge that makes bit_cnt=8, go to LATCH and clear bit_cnt.
- LATCH (1 cycle): addr_we=1; txn_is_read<=sr_data[0]. If sr_data[0]=1, go to RD_WAIT with wait_cnt=0; else go to WR_SHIFT.
- RD_WAIT: wait_cnt increments each clk. When wait_cnt=RD_WAIT_CYCLES-1, go to RD_LOAD.
- RD_LOAD (1 cycle): sr_load=1, miso_en=1; go to RD_SHIFT.
- RD_SHIFT: miso_en=1; count edges. On the 8th edge, go to DONE.
- WR_SHIFT: count edges. On the 8th edge, go to WR_COMMIT.
  - The shift register updates on the same clk as the edge, so sr_data is final in WR_COMMIT.
- WR_COMMIT (1 cycle): dm_we=1. Always goes to DONE, even if cs_n=1 that cycle: a started commit completes and no abort is raised.
- DONE: all strobes 0; further edges are ignored and the counter is frozen. When cs_n=1, go to IDLE.
- Abort: cs_n=1 in CMD, LATCH, RD_WAIT, RD_LOAD, RD_SHIFT or WR_SHIFT → IDLE next clk, txn_abort=1 for one clk, bit_cnt cleared.
  - No dm_we is issued for an aborted write. An aborted read drops miso_en on the next clk.
- Simultaneous cs_n=1 and sclk_posedge: cs_n wins; the edge is not counted.
- fault_hold=1 together with sclk_posedge: the edge is ignored, keeping the controller aligned with the frozen shift register.
- Interface timing requirement: SCLK half-period ≥ RD_WAIT_CYCLES+3 clk. This guarantees sr_load completes before the first SCLK falling edge after the command byte.
- bit_cnt never exceeds 8.

Test Plan:
- Write 0x55 to address 1: cs_n=0, shift 0x02 then 0x55 → addr_we pulses one clk after the 8th edge; txn_is_read=0; dm_we pulses one clk after the 16th edge; txn_done pulses; state_out=8 until cs_n=1, then 0.
- Read address 1: shift 0x03 → addr_we pulse; 2 clk RD_WAIT; sr_load one clk; miso_en=1 from RD_LOAD through the 16th edge; txn_is_read=1; no dm_we.
- Abort write: cs_n=0, 0x02, then 4 data bits, then cs_n=1 → txn_abort one clk, state=IDLE, dm_we never asserted. The next full write completes normally.
- fault_hold=1 during 3 edges of the command byte → those edges are uncounted; LATCH is reached only after 8 unheld edges.
- cs_n rises in the same clk as the 8th data edge of a write → abort, no dm_we. cs_n rises during WR_COMMIT → dm_we still pulses and txn_done pulses.
- rst_n low for 1 clk during RD_SHIFT → all outputs 0 asynchronously; state_out=0; with cs_n held low, CMD resumes counting from 0.
